// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol/disparity widths, DVI control tokens and small helpers.
package tmds_pkg;

  localparam int SYM_W  = 10;
  localparam int DISP_W = 5;

  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Control token for C1C0 = c
  function automatic logic [SYM_W-1:0] ctrlToken(input logic [1:0] c);
    logic [SYM_W-1:0] t;
    case (c)
      2'b00:   t = CTRL_00;
      2'b01:   t = CTRL_01;
      2'b10:   t = CTRL_10;
      default: t = CTRL_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel/sync inputs and encoded TMDS symbols of the three-channel encoder.
interface tmds_encoder_if;
  import tmds_pkg::*;

  logic [7:0]       red;
  logic [7:0]       green;
  logic [7:0]       blue;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic [SYM_W-1:0] tmds_0;
  logic [SYM_W-1:0] tmds_1;
  logic [SYM_W-1:0] tmds_2;

  modport master (
    output red, green, blue, de, hsync, vsync,
    input  tmds_0, tmds_1, tmds_2
  );

  modport slave (
    input  red, green, blue, de, hsync, vsync,
    output tmds_0, tmds_1, tmds_2
  );

endinterface

// File: rtl/tmds_channel.sv
// One TMDS channel: stage 1 transition minimisation, stage 2 DC balance with a
// running disparity counter, both registered for a fixed 2-cycle latency.
module tmds_channel
  import tmds_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       d,
  input  logic             de,
  input  logic [1:0]       c,
  output logic [SYM_W-1:0] sym_o
);

  logic [8:0]        qm_d, qm_q;
  logic              de_q;
  logic [1:0]        c_q;
  logic [DISP_W-1:0] cnt_d, cnt_q;
  logic [SYM_W-1:0]  sym_d, sym_q;

  logic [3:0]        nOnesD;
  logic              useXnor;
  logic [3:0]        n1;
  logic [DISP_W-1:0] bal;
  logic [DISP_W-1:0] twoQm8;
  logic [DISP_W-1:0] twoNotQm8;
  logic              cntZero, cntPos, cntNeg;
  logic              qm8;

  always_comb begin
    nOnesD  = popcount8(d);
    useXnor = (nOnesD > 4'd4) || ((nOnesD == 4'd4) && !d[0]);
    qm_d    = '0;
    qm_d[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = useXnor ? ~(qm_d[i-1] ^ d[i]) : (qm_d[i-1] ^ d[i]);
    end
    qm_d[8] = ~useXnor;
  end

  // Disparity terms are kept modulo 2^DISP_W; the counter never leaves [-10, +10].
  assign qm8       = qm_q[8];
  assign n1        = popcount8(qm_q[7:0]);
  assign bal       = {n1, 1'b0} - DISP_W'(8);
  assign twoQm8    = {3'b000, qm8, 1'b0};
  assign twoNotQm8 = {3'b000, ~qm8, 1'b0};
  assign cntZero   = (cnt_q == '0);
  assign cntNeg    = cnt_q[DISP_W-1];
  assign cntPos    = !cntNeg && !cntZero;

  always_comb begin
    sym_d = sym_q;
    cnt_d = cnt_q;
    if (!de_q) begin
      sym_d = ctrlToken(c_q);
      cnt_d = '0;
    end else if (cntZero || (n1 == 4'd4)) begin
      sym_d = {~qm8, qm8, (qm8 ? qm_q[7:0] : ~qm_q[7:0])};
      cnt_d = qm8 ? (cnt_q + bal) : (cnt_q - bal);
    end else if ((cntPos && (n1 > 4'd4)) || (cntNeg && (n1 < 4'd4))) begin
      sym_d = {1'b1, qm8, ~qm_q[7:0]};
      cnt_d = cnt_q + twoQm8 - bal;
    end else begin
      sym_d = {1'b0, qm8, qm_q[7:0]};
      cnt_d = cnt_q + bal - twoNotQm8;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qm_q  <= '0;
      de_q  <= 1'b0;
      c_q   <= 2'b00;
      cnt_q <= '0;
      sym_q <= CTRL_00;
    end else begin
      qm_q  <= qm_d;
      de_q  <= de;
      c_q   <= c;
      cnt_q <= cnt_d;
      sym_q <= sym_d;
    end
  end

  assign sym_o = sym_q;

endmodule

// File: rtl/tmds_encoder.sv
// Three-channel DVI 1.0 TMDS encoder; blue carries hsync/vsync, green/red send C1C0 = 00.
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic         clk_pixel,
  input  logic         reset,
  tmds_encoder_if.slave bus
);

  tmds_channel u_ch0 (
    .clk   (clk_pixel),
    .rst   (reset),
    .d     (bus.blue),
    .de    (bus.de),
    .c     ({bus.vsync, bus.hsync}),
    .sym_o (bus.tmds_0)
  );

  tmds_channel u_ch1 (
    .clk   (clk_pixel),
    .rst   (reset),
    .d     (bus.green),
    .de    (bus.de),
    .c     (2'b00),
    .sym_o (bus.tmds_1)
  );

  tmds_channel u_ch2 (
    .clk   (clk_pixel),
    .rst   (reset),
    .d     (bus.red),
    .de    (bus.de),
    .c     (2'b00),
    .sym_o (bus.tmds_2)
  );

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed literal cases plus a random soak
// against a behavioural DVI 1.0 encoder model.
module tb_tmds_encoder;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  bit   checkEn   = 1'b0;

  tmds_encoder_if bus ();

  tmds_encoder dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Behavioural model state: one-cycle-old sample plus per-channel disparity.
  int         modelCnt [3];
  logic [7:0] prevD [3];
  logic       prevDe;
  logic [1:0] prevC;
  logic [9:0] expSym [3];
  logic       expDe;
  int         runDisp [3];

  function automatic int onesOf(input logic [9:0] v, input int width);
    int n = 0;
    for (int i = 0; i < width; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [9:0] modelEncode(input int ch, input logic [7:0] d,
                                             input logic de, input logic [1:0] c);
    logic [7:0] qm;
    logic       qm8;
    int         ones, bal;
    logic [9:0] sym;
    if (!de) begin
      modelCnt[ch] = 0;
      case (c)
        2'b00:   return 10'b1101010100;
        2'b01:   return 10'b0010101011;
        2'b10:   return 10'b0101010100;
        default: return 10'b1010101011;
      endcase
    end
    ones = onesOf({2'b00, d}, 8);
    qm8  = !((ones > 4) || (ones == 4 && d[0] == 1'b0));
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = qm8 ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    bal = onesOf({2'b00, qm}, 8) * 2 - 8;
    if (modelCnt[ch] == 0 || bal == 0) begin
      sym = qm8 ? {2'b01, qm} : {2'b10, ~qm};
      modelCnt[ch] += qm8 ? bal : -bal;
    end else if ((modelCnt[ch] > 0 && bal > 0) || (modelCnt[ch] < 0 && bal < 0)) begin
      sym = {1'b1, qm8, ~qm};
      modelCnt[ch] += 2 * int'(qm8) - bal;
    end else begin
      sym = {1'b0, qm8, qm};
      modelCnt[ch] += bal - (qm8 ? 0 : 2);
    end
    return sym;
  endfunction

  function automatic logic [9:0] dutSym(input int ch);
    case (ch)
      0:       return bus.tmds_0;
      1:       return bus.tmds_1;
      default: return bus.tmds_2;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input logic hs, input logic vs);
    @(negedge clk_pixel);
    bus.de    = v;
    bus.red   = r;
    bus.green = g;
    bus.blue  = b;
    bus.hsync = hs;
    bus.vsync = vs;
  endtask

  // Model advances on every edge; reset forces the idle token and clears everything.
  always @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < 3; ch++) begin
        modelCnt[ch] = 0;
        expSym[ch]   = 10'b1101010100;
        prevD[ch]    = 8'h00;
      end
      prevDe = 1'b0;
      prevC  = 2'b00;
      expDe  = 1'b0;
    end else begin
      expDe     = prevDe;
      expSym[0] = modelEncode(0, prevD[0], prevDe, prevC);
      expSym[1] = modelEncode(1, prevD[1], prevDe, 2'b00);
      expSym[2] = modelEncode(2, prevD[2], prevDe, 2'b00);
      prevD[0]  = bus.blue;
      prevD[1]  = bus.green;
      prevD[2]  = bus.red;
      prevDe    = bus.de;
      prevC     = {bus.vsync, bus.hsync};
    end
  end

  // Compare process: bit-exact symbols plus the DUT stream's own running disparity.
  always @(negedge clk_pixel) begin
    if (checkEn) begin
      for (int ch = 0; ch < 3; ch++) begin
        logic [9:0] got;
        got = dutSym(ch);
        checkOutput($sformatf("model ch%0d", ch), got, expSym[ch]);
        if (expDe && !reset) begin
          runDisp[ch] += onesOf(got, 10) * 2 - 10;
          checks++;
          if (runDisp[ch] > 10 || runDisp[ch] < -10) begin
            errors++;
            $display("[TB] FAIL disparity ch%0d: running %0d, limit +/-10 at %0t",
                     ch, runDisp[ch], $time);
          end
        end else begin
          runDisp[ch] = 0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: time %0t, limit 5000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int total;
    bus.red = 8'h5A; bus.green = 8'hC3; bus.blue = 8'h81;
    bus.de = 1'b1; bus.hsync = 1'b1; bus.vsync = 1'b1;
    for (int ch = 0; ch < 3; ch++) runDisp[ch] = 0;

    #1 reset = 1'b1;
    #1;
    checkOutput("reset tmds_0", bus.tmds_0, 10'b1101010100);
    checkOutput("reset tmds_1", bus.tmds_1, 10'b1101010100);
    checkOutput("reset tmds_2", bus.tmds_2, 10'b1101010100);
    checkEn = 1'b1;

    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    reset = 1'b0;
    repeat (3) begin
      applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
      checkOutput("idle tmds_0", bus.tmds_0, 10'b1101010100);
    end

    repeat (3) applyStimulus(0, 8'h11, 8'h22, 8'h33, 1, 0);
    checkOutput("hsync tmds_0", bus.tmds_0, 10'b0010101011);
    checkOutput("hsync tmds_1", bus.tmds_1, 10'b1101010100);
    checkOutput("hsync tmds_2", bus.tmds_2, 10'b1101010100);
    repeat (3) applyStimulus(0, 8'h44, 8'h55, 8'h66, 1, 1);
    checkOutput("vhsync tmds_0", bus.tmds_0, 10'b1010101011);

    repeat (2) applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    repeat (3) applyStimulus(1, 8'h00, 8'h00, 8'h00, 1, 1);
    checkOutput("zero px 1", bus.tmds_0, 10'b0100000000);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    checkOutput("zero px 2", bus.tmds_0, 10'b1111111111);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    checkOutput("zero px 3", bus.tmds_0, 10'b0100000000);

    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus(1, 8'hFF, 8'h00, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    checkOutput("full red", bus.tmds_2, 10'b1000000000);

    repeat (2) applyStimulus(1, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus(1, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    checkOutput("gap token", bus.tmds_0, 10'b1101010100);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    checkOutput("cnt cleared", bus.tmds_0, 10'b0100000000);

    repeat (3) applyStimulus(1, 8'h00, 8'h37, 8'hC8, 0, 0);
    @(posedge clk_pixel);
    #2 reset = 1'b1;
    #1;
    checkOutput("midline rst 0", bus.tmds_0, 10'b1101010100);
    checkOutput("midline rst 1", bus.tmds_1, 10'b1101010100);
    checkOutput("midline rst 2", bus.tmds_2, 10'b1101010100);
    applyStimulus(1, 8'h00, 8'h00, 8'h00, 0, 0);
    applyStimulus(1, 8'h00, 8'h00, 8'h00, 0, 0);
    reset = 1'b0;
    applyStimulus(1, 8'h00, 8'h00, 8'h00, 0, 0);
    checkOutput("post rst token", bus.tmds_0, 10'b1101010100);
    applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);
    checkOutput("post rst data", bus.tmds_0, 10'b0100000000);

    total = 0;
    while (total < 10000) begin
      int vLen, cLen;
      vLen = $urandom_range(1, 40);
      cLen = $urandom_range(1, 6);
      for (int i = 0; i < vLen; i++) begin
        logic [7:0] r, g, b;
        r = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        g = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        b = 8'($urandom);
        applyStimulus(1, r, g, b, 1'($urandom), 1'($urandom));
      end
      for (int i = 0; i < cLen; i++) begin
        applyStimulus(0, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end
      total += vLen + cLen;
    end
    repeat (3) applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 0);

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
